// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with full/empty flags and registered read data.
//
// Parameters:
//   DATA_WIDTH - width of each stored word and of data_in/data_out
//   DEPTH      - number of entries (power of two, >= 2)
//   ADDR_WIDTH - log2(DEPTH)
//
// Ports:
//   clk      - rising-edge clock for all state
//   rst      - asynchronous active-low reset
//   write_en - write request, accepted when not full (or when a read is accepted too)
//   read_en  - read request, accepted when not empty
//   data_in  - write data, stored on an accepted write
//   full     - DEPTH entries stored
//   empty    - no entries stored
//   data_out - registered read data, updated only on an accepted read
module sync_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_en,
   input  logic                  read_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam logic [ADDR_WIDTH:0] PtrOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
   logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] waddr;
   logic [ADDR_WIDTH-1:0] raddr;
   logic                  wr_acc;
   logic                  rd_acc;

   always_comb begin
      waddr = wptr_q[ADDR_WIDTH-1:0];
      raddr = rptr_q[ADDR_WIDTH-1:0];
      empty = (wptr_q == rptr_q);
      full  = (waddr == raddr) && (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

      rd_acc = read_en && !empty;
      // A write into a full FIFO is fine when the same edge frees a slot.
      wr_acc = write_en && (!full || rd_acc);

      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      data_out_d = data_out_q;
      if (wr_acc) begin
         wptr_d = wptr_q + PtrOne;
      end
      if (rd_acc) begin
         rptr_d     = rptr_q + PtrOne;
         data_out_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         data_out_q <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[waddr] <= data_in;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_sync_fifo;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          write_en;
   logic          read_en;
   logic [DW-1:0] data_in;
   logic          full;
   logic          empty;
   logic [DW-1:0] data_out;

   int unsigned err_cnt = 0;
   int unsigned chk_cnt = 0;

   logic [DW-1:0] model_q[$];
   logic [DW-1:0] exp_dout;

   always #2 clk = ~clk;

   sync_fifo #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .write_en(write_en),
      .read_en (read_en),
      .data_in (data_in),
      .full    (full),
      .empty   (empty),
      .data_out(data_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".empty"}, {31'd0, empty}, {31'd0, model_q.size() == 0});
      check({tag, ".full"}, {31'd0, full}, {31'd0, model_q.size() == DEPTH});
      check({tag, ".dout"}, {24'd0, data_out}, {24'd0, exp_dout});
   endtask

   // One clock: drive inputs, advance the model on the edge, check #1 later.
   task automatic step(input logic we, input logic re, input logic [DW-1:0] din,
                       input string tag);
      bit rd_ok;
      bit wr_ok;
      write_en = we;
      read_en  = re;
      data_in  = din;
      @(posedge clk);
      rd_ok = re && (model_q.size() > 0);
      wr_ok = we && ((model_q.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(din);
      #1;
      check_model(tag);
   endtask

   initial begin
      rst      = 1'b0;
      write_en = 1'b0;
      read_en  = 1'b0;
      data_in  = '0;
      exp_dout = '0;

      // Reset held with the clock running.
      #5;
      check("rst.empty", {31'd0, empty}, 32'd1);
      check("rst.full", {31'd0, full}, 32'd0);
      check("rst.dout", {24'd0, data_out}, 32'h00);
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 1'b0, 8'h00, "idle0");
      step(1'b0, 1'b1, 8'h00, "idle_rd");

      // Fill, then one ignored overflow write.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0, 8'(8'h10 + i), "fill");
         if (i == 0) check("fill.first_not_empty", {31'd0, empty}, 32'd0);
      end
      check("fill.full", {31'd0, full}, 32'd1);
      step(1'b1, 1'b0, 8'hAA, "overflow");

      // Drain in order, then one ignored underflow read.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 8'h00, "drain");
         check("drain.order", {24'd0, data_out}, 32'(8'h10 + i));
      end
      check("drain.empty", {31'd0, empty}, 32'd1);
      step(1'b0, 1'b1, 8'h00, "underflow");
      check("underflow.hold", {24'd0, data_out}, 32'h1F);

      // Wrap-around.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom), "wrap_w");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, "wrap_r");
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h20 + i), "wrap_fill");
      check("wrap.full", {31'd0, full}, 32'd1);

      // Simultaneous read/write while full.
      step(1'b1, 1'b1, 8'h55, "full_rw");
      check("full_rw.oldest", {24'd0, data_out}, 32'h20);
      check("full_rw.still_full", {31'd0, full}, 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 8'h00, "full_rw_drain");
         if (i < DEPTH - 1) check("wrap.order", {24'd0, data_out}, 32'(8'h21 + i));
      end
      check("full_rw.last", {24'd0, data_out}, 32'h55);

      // Simultaneous read/write while empty: write only, no fall-through.
      step(1'b1, 1'b1, 8'h66, "empty_rw");
      check("empty_rw.hold", {24'd0, data_out}, 32'h55);
      check("empty_rw.not_empty", {31'd0, empty}, 32'd0);
      step(1'b0, 1'b1, 8'h00, "empty_rw_rd");
      check("empty_rw.data", {24'd0, data_out}, 32'h66);

      // Asynchronous reset mid-operation.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h70 + i), "pre_rst");
      write_en = 1'b0;
      rst      = 1'b0;
      #0.5;
      check("arst.empty", {31'd0, empty}, 32'd1);
      check("arst.full", {31'd0, full}, 32'd0);
      check("arst.dout", {24'd0, data_out}, 32'h00);
      model_q.delete();
      exp_dout = '0;
      #1;
      rst = 1'b1;
      step(1'b0, 1'b1, 8'h00, "post_rst_rd");

      // Randomized traffic: write-heavy, read-heavy, then balanced phases.
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 600; i++) begin
            int unsigned wp;
            int unsigned rp;
            wp = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
            rp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
            step($urandom_range(99) < wp, $urandom_range(99) < rp, 8'($urandom), "rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
